uart_rx_frame: RTL

//   Serial-to-byte UART receiver. Feeds the core's byte-input port (r_data / receiver_valid)
//   and fills its input buffer for the in/fin instructions. Handles 8N1 framing, LSB first,
//   at a fixed baud of one bit per 2*CLK_PER_HALF_BIT clocks. Mid-bit sampling.

---
 rtl/uart_rx_frame_pkg.sv | 22 ++
 rtl/uart_rx_frame_if.sv | 14 +
 rtl/uart_rx_frame_sync2.sv | 23 ++
 rtl/uart_rx_frame.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receiver definitions: FSM states, frame constants, parity helper.
// Optional build macro UART_RX_PARITY_EN selects 8E1 framing in uart_rx_frame.
package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        IDLE_LEVEL     = 1'b1;

    // Value of the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial line and received-byte outputs of the UART receiver.
interface uart_rx_frame_if;
    import uart_rx_frame_pkg::*;

    logic                      rxd;
    logic [UART_DATA_BITS-1:0] rdata;
    logic                      rdata_valid;
    logic                      ferr;
    logic                      perr;

    modport master (output rxd, input rdata, rdata_valid, ferr, perr);
    modport slave  (input rxd, output rdata, rdata_valid, ferr, perr);

endinterface

// File: rtl/uart_rx_frame_sync2.sv
// Two-flop synchroniser with asynchronous reset to a configurable level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver, 8N1 LSB first with mid-bit sampling; define UART_RX_PARITY_EN for 8E1.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int unsigned CLK_PER_HALF_BIT = 520
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_frame_if.slave bus
);

    localparam int unsigned H  = CLK_PER_HALF_BIT;
    localparam int unsigned CW = $clog2(2 * H);

    logic                      rx_s;
    rx_state_t                 state, state_next;
    logic [CW-1:0]             cnt;
    logic [2:0]                bidx;
    logic [UART_DATA_BITS-1:0] sh;
    logic [UART_DATA_BITS-1:0] rdata_q;
    logic                      valid_q, ferr_q;
    logic                      tick, shift_en, valid_d, ferr_d;

    sync2 #(.RST_VAL(IDLE_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rxd),
        .q   (rx_s)
    );

    // START waits half a bit to reach the middle of the start bit; later states wait a full bit.
    always_comb begin
        tick = 1'b0;
        if (state == START) tick = (cnt == CW'(H - 1));
        else                tick = (cnt == CW'(2 * H - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!rx_s) state_next = START;
            START:  if (tick) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (tick && bidx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: if (tick) state_next = STOP;
            STOP:   if (tick) state_next = rx_s ? IDLE : BREAK;
            BREAK:  if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic perr_pend, perr_d, perr_q;
`endif

    always_comb begin
        shift_en = (state == DATA) && tick;
        ferr_d   = (state == STOP) && tick && !rx_s;
`ifdef UART_RX_PARITY_EN
        valid_d  = (state == STOP) && tick && rx_s && !perr_pend;
        perr_d   = (state == STOP) && tick && rx_s && perr_pend;
`else
        valid_d  = (state == STOP) && tick && rx_s;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bidx    <= '0;
            sh      <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            if (state == IDLE || state == BREAK || tick) cnt <= '0;
            else                                          cnt <= cnt + CW'(1);
            if (state == START && tick) bidx <= '0;
            else if (shift_en)          bidx <= bidx + 3'd1;
            if (shift_en) sh      <= {rx_s, sh[UART_DATA_BITS-1:1]};
            if (valid_d)  rdata_q <= sh;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_pend <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            perr_q <= perr_d;
            if (state == PARITY && tick) perr_pend <= (rx_s != even_parity(sh));
        end
    end
    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = valid_q;
    assign bus.ferr        = ferr_q;

endmodule
